// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl
//   Debug readout controller for the register file. On dump_start (in IDLE)
//   it gates off pipeline writes, takes over the A1 read port, walks
//   registers 0..NREG-1 and streams each word MSB-first as four bytes over
//   a valid/ready byte interface toward the UART transmitter.
//
// Ports
//   clk         system clock, rising edge
//   inicio      asynchronous active-high reset
//   dump_start  dump request, honored only in IDLE
//   pipe_a1     pipeline A1 read address (passed through in IDLE)
//   rf_a1       address to register file A1
//   rf_rd1      register file RD1 (combinational read of rf_a1)
//   activo      register file write gate, 0 while a dump is in progress
//   tx_data     byte to transmitter
//   tx_valid    tx_data valid
//   tx_ready    transmitter accepts byte when high with tx_valid
//   busy        high in any state other than IDLE
//   done        one-cycle pulse at dump completion
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | pipeline owns A1, writes enabled, waiting for dump_start
// LOAD  | A1 = idx, capture rf_rd1 into word
// SEND  | present word[31:24], shift on each accepted byte
// DONE  | one-cycle completion pulse, then back to IDLE

module reg_dump_ctrl #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          inicio,
    input  logic          dump_start,
    input  logic [AW-1:0] pipe_a1,
    output logic [AW-1:0] rf_a1,
    input  logic [DW-1:0] rf_rd1,
    output logic          activo,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [DW-1:0] word;
    logic [1:0]    bcnt;

    always_ff @(posedge clk or posedge inicio) begin
        if (inicio) begin
            state <= IDLE;
            idx   <= '0;
            word  <= '0;
            bcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        idx   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    word  <= rf_rd1;
                    bcnt  <= '0;
                    state <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (bcnt != 2'd3) begin
                            word <= word << 8;
                            bcnt <= bcnt + 2'd1;
                        end else if (idx != LAST_IDX) begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Unconditional: a dump_start seen here is deliberately dropped.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state register only, so the async reset
    // drops them immediately and no input can glitch them.
    always_comb begin
        rf_a1    = (state == IDLE) ? pipe_a1 : idx;
        activo   = (state == IDLE);
        busy     = (state != IDLE);
        tx_valid = (state == SEND);
        done     = (state == DONE);
        tx_data  = (state == SEND) ? word[DW-1 -: 8] : 8'h00;
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl with a behavioral register file model.
module tb_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        inicio;
    logic        dump_start;
    logic [4:0]  pipe_a1;
    logic [4:0]  rf_a1;
    logic [31:0] rf_rd1;
    logic        activo;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] rf_mem [32];
    logic [7:0]  q[$];
    int          n_done;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    assign rf_rd1 = rf_mem[rf_a1];

    reg_dump_ctrl #(.NREG(32), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .inicio     (inicio),
        .dump_start (dump_start),
        .pipe_a1    (pipe_a1),
        .rf_a1      (rf_a1),
        .rf_rd1     (rf_rd1),
        .activo     (activo),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always @(negedge clk) begin
        if (!inicio && tx_valid && tx_ready) q.push_back(tx_data);
        if (!inicio && done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] get_b(input int i);
        if (i >= 0 && i < q.size()) return {24'h0, q[i]};
        return 32'hxxxx_xxxx;
    endfunction

    // Pulse dump_start over one edge; returns in cycle 1 of the dump.
    task automatic start_dump();
        q.delete();
        n_done = 0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    initial begin
        int act_bad;
        int done_cyc;
        int c;
        total = 0;
        bad = 0;
        n_done = 0;
        for (int k = 0; k < 32; k++) rf_mem[k] = 32'hA0B0_C000 + k;

        // Reset with random inputs
        inicio     = 1'b1;
        dump_start = 1'($urandom_range(0, 1));
        tx_ready   = 1'($urandom_range(0, 1));
        pipe_a1    = 5'd7;
        #2;
        tick();
        chk("rst_tx_valid", {31'b0, tx_valid}, 0);
        chk("rst_busy",     {31'b0, busy}, 0);
        chk("rst_done",     {31'b0, done}, 0);
        chk("rst_activo",   {31'b0, activo}, 1);
        chk("rst_tx_data",  {24'b0, tx_data}, 32'h00);
        chk("rst_rf_a1",    {27'b0, rf_a1}, 7);
        dump_start = 1'b0;
        tx_ready   = 1'b1;
        tick();
        inicio = 1'b0;
        tick();

        // Full dump, tx_ready held high
        start_dump();
        act_bad  = 0;
        done_cyc = 0;
        for (int cy = 1; cy <= 161; cy++) begin
            if (activo !== 1'b0 || busy !== 1'b1) act_bad++;
            if (done) done_cyc = cy;
            tick();
        end
        chk("full_activo_busy", act_bad, 0);
        chk("full_done_cyc", done_cyc, 161);
        chk("full_n_done", n_done, 1);
        chk("full_busy_162", {31'b0, busy}, 0);
        chk("full_done_162", {31'b0, done}, 0);
        chk("full_bytes", q.size(), 128);
        chk("full_b0", get_b(0), 32'hA0);
        chk("full_b1", get_b(1), 32'hB0);
        chk("full_b2", get_b(2), 32'hC0);
        chk("full_b3", get_b(3), 32'h00);
        chk("full_b124", get_b(124), 32'hA0);
        chk("full_b125", get_b(125), 32'hB0);
        chk("full_b126", get_b(126), 32'hC0);
        chk("full_b127", get_b(127), 32'h1F);
        tick();

        // Backpressure on reg 3 byte 2 (cycles 19..21)
        start_dump();
        done_cyc = 0;
        c = 1;
        while (c <= 300 && done_cyc == 0) begin
            tx_ready = !(c >= 19 && c <= 21);
            if (c >= 19 && c <= 22) begin
                chk("bp_hold_data", {24'b0, tx_data}, 32'hC0);
                chk("bp_hold_valid", {31'b0, tx_valid}, 1);
            end
            if (c == 23) chk("bp_resume", {24'b0, tx_data}, 32'h03);
            if (done) done_cyc = c;
            tick();
            c++;
        end
        tx_ready = 1'b1;
        chk("bp_done_cyc", done_cyc, 164);
        chk("bp_bytes", q.size(), 128);
        chk("bp_b14", get_b(14), 32'hC0);
        chk("bp_b15", get_b(15), 32'h03);
        chk("bp_idle", {31'b0, busy}, 0);
        tick();

        // dump_start while busy, including the DONE cycle
        start_dump();
        for (int cy = 1; cy <= 170; cy++) begin
            dump_start = (cy == 10 || cy == 161);
            if (cy == 161) chk("sb_done_161", {31'b0, done}, 1);
            tick();
        end
        dump_start = 1'b0;
        chk("sb_n_done", n_done, 1);
        chk("sb_bytes", q.size(), 128);
        chk("sb_busy", {31'b0, busy}, 0);

        // Reset mid-dump in cycle 50
        start_dump();
        for (int cy = 1; cy < 50; cy++) tick();
        chk("mid_busy_pre", {31'b0, busy}, 1);
        inicio = 1'b1;
        #1;
        chk("mid_tx_valid", {31'b0, tx_valid}, 0);
        chk("mid_busy",     {31'b0, busy}, 0);
        chk("mid_done",     {31'b0, done}, 0);
        chk("mid_activo",   {31'b0, activo}, 1);
        chk("mid_tx_data",  {24'b0, tx_data}, 32'h00);
        tick();
        inicio = 1'b0;
        tick();
        start_dump();
        done_cyc = 0;
        c = 1;
        while (c <= 300 && done_cyc == 0) begin
            if (done) done_cyc = c;
            tick();
            c++;
        end
        chk("mid_redo_done", done_cyc, 161);
        chk("mid_redo_b0", get_b(0), 32'hA0);
        chk("mid_redo_b3", get_b(3), 32'h00);
        chk("mid_redo_bytes", q.size(), 128);

        // Idle mux sweep
        act_bad = 0;
        for (int a = 0; a < 32; a++) begin
            pipe_a1 = 5'(a);
            #1;
            chk("idle_rf_a1", {27'b0, rf_a1}, a);
            if (activo !== 1'b1 || tx_valid !== 1'b0) act_bad++;
            tick();
        end
        chk("idle_activo_valid", act_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
